// File: rtl/an_codes_pkg.sv
// Shared AN-code definitions: default code geometry, decoder states, syndrome helper.
package an_codes_pkg;

  localparam int unsigned AN_A      = 19;
  localparam int unsigned AN_CODE_W = 9;
  localparam int unsigned AN_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RESID,
    CORR,
    DIV,
    RESP
  } state_t;

  // 2^k mod a, evaluated at elaboration time to build syndrome tables
  function automatic int unsigned pow2_mod(input int unsigned k, input int unsigned a);
    int unsigned r;
    r = 1 % a;
    for (int unsigned i = 0; i < k; i++) begin
      r = (2 * r) % a;
    end
    return r;
  endfunction

endpackage

// File: rtl/an_syndrome_rom.sv
// Residue -> single arithmetic error lookup: {hit, sign (0=subtract,1=add), bit position}.
module an_syndrome_rom
  import an_codes_pkg::*;
#(
  parameter int unsigned A      = AN_A,
  parameter int unsigned CODE_W = AN_CODE_W,
  parameter int unsigned MOD_W  = $clog2(A),
  parameter int unsigned POS_W  = $clog2(CODE_W)
) (
  input  logic [MOD_W-1:0] residue,
  output logic             hit_c,
  output logic             sign_c,
  output logic [POS_W-1:0] bitpos_c
);

  logic [MOD_W-1:0] pos_tab [CODE_W];
  logic [MOD_W-1:0] neg_tab [CODE_W];

  // Table entries: +2^k error leaves residue 2^k mod A, -2^k leaves A - (2^k mod A)
  for (genvar k = 0; k < CODE_W; k++) begin : g_tab
    localparam int unsigned P = pow2_mod(k, A);
    assign pos_tab[k] = MOD_W'(P);
    assign neg_tab[k] = MOD_W'(A - P);
  end

  // Priority search: walking downward lets the lowest k (and its +2^k entry) win
  always_comb begin
    hit_c    = 1'b0;
    sign_c   = 1'b0;
    bitpos_c = '0;
    for (int k = int'(CODE_W) - 1; k >= 0; k--) begin
      if (residue == neg_tab[k]) begin
        hit_c    = 1'b1;
        sign_c   = 1'b1;
        bitpos_c = POS_W'(k);
      end
      if (residue == pos_tab[k]) begin
        hit_c    = 1'b1;
        sign_c   = 1'b0;
        bitpos_c = POS_W'(k);
      end
    end
  end

endmodule

// File: rtl/an_decode_scheduler.sv
// Shared multi-cycle AN-code decoder with round-robin request arbitration.
module an_decode_scheduler
  import an_codes_pkg::*;
#(
  parameter int unsigned A      = AN_A,
  parameter int unsigned CODE_W = AN_CODE_W,
  parameter int unsigned DATA_W = AN_DATA_W,
  parameter int unsigned MOD_W  = $clog2(A),
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ID_W   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_corrected,
  output logic                     rsp_uncorr
);

  localparam int unsigned CNT_W = $clog2(CODE_W);
  localparam int unsigned EXT_W = CODE_W + 1;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q;
  logic [ID_W-1:0]   id_q, rr_q;
  logic [MOD_W-1:0]  r_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bad_q, fix_q;

  logic [CODE_W-1:0] code_arr [NREQ];
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any, accept, last;
  int unsigned       best_off, off;

  logic [MOD_W:0]    step_t;
  logic              step_ge;
  logic [MOD_W-1:0]  step_r;
  logic [CODE_W-1:0] q_next;
  logic              out_of_range;

  logic              syn_hit, syn_sign;
  logic [CNT_W-1:0]  syn_pos;
  logic [EXT_W-1:0]  flip, fixed;

  for (genvar g = 0; g < NREQ; g++) begin : g_code
    assign code_arr[g] = req_code[g*CODE_W +: CODE_W];
  end

  // Round-robin pick: smallest rotated distance from the pointer among valid requesters
  always_comb begin
    gnt_id   = '0;
    gnt_any  = 1'b0;
    best_off = NREQ;
    off      = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      off = (j + NREQ - 32'(rr_q)) % NREQ;
      if (req_valid[j] && off < best_off) begin
        best_off = off;
        gnt_id   = ID_W'(j);
        gnt_any  = 1'b1;
      end
    end
  end

  // Grant is only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == IDLE && !rst && gnt_any) begin
      req_ready[gnt_id] = 1'b1;
      accept            = 1'b1;
    end
  end

  // Shared shift/conditional-subtract step: residue accumulation and restoring division
  assign step_t       = {r_q, code_q[CODE_W-1]};
  assign step_ge      = step_t >= (MOD_W+1)'(A);
  assign step_r       = step_ge ? MOD_W'(step_t - (MOD_W+1)'(A)) : step_t[MOD_W-1:0];
  assign q_next       = {code_q[CODE_W-2:0], step_ge};
  assign out_of_range = |q_next[CODE_W-1:DATA_W];
  assign last         = cnt_q == CNT_W'(CODE_W - 1);

  an_syndrome_rom #(
    .A      (A),
    .CODE_W (CODE_W),
    .MOD_W  (MOD_W),
    .POS_W  (CNT_W)
  ) u_rom (
    .residue  (r_q),
    .hit_c    (syn_hit),
    .sign_c   (syn_sign),
    .bitpos_c (syn_pos)
  );

  // One extra bit so underflow and overflow both show up in the top bit
  assign flip  = EXT_W'(1) << syn_pos;
  assign fixed = syn_sign ? ({1'b0, code_q} + flip) : ({1'b0, code_q} - flip);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RESID;
      RESID:   if (last)      state_d = CORR;
      CORR:                   state_d = DIV;
      DIV:     if (last)      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= '0;
      code_q        <= '0;
      id_q          <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      bad_q         <= 1'b0;
      fix_q         <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_data      <= '0;
      rsp_corrected <= 1'b0;
      rsp_uncorr    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            code_q <= code_arr[gnt_id];
            id_q   <= gnt_id;
            rr_q   <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            r_q    <= '0;
            cnt_q  <= '0;
            bad_q  <= 1'b0;
            fix_q  <= 1'b0;
          end
        end
        RESID: begin
          // Rotating by CODE_W positions leaves the codeword intact for correction
          r_q    <= step_r;
          code_q <= {code_q[CODE_W-2:0], code_q[CODE_W-1]};
          cnt_q  <= last ? '0 : cnt_q + 1'b1;
        end
        CORR: begin
          r_q   <= '0;
          cnt_q <= '0;
          if (r_q != '0) begin
            if (!syn_hit || fixed[CODE_W]) begin
              bad_q <= 1'b1;
            end else begin
              code_q <= fixed[CODE_W-1:0];
              fix_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          r_q    <= step_r;
          code_q <= q_next;
          cnt_q  <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            if (bad_q || out_of_range) begin
              rsp_data      <= '0;
              rsp_corrected <= 1'b0;
              rsp_uncorr    <= 1'b1;
            end else begin
              rsp_data      <= q_next[DATA_W-1:0];
              rsp_corrected <= fix_q;
              rsp_uncorr    <= 1'b0;
            end
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_decode_scheduler.sv
// Directed self-checking bench for the shared AN-code decoder.
module tb_an_decode_scheduler;

  localparam int CW = 9;
  localparam int NR = 4;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*CW-1:0] req_code;
  logic [NR-1:0]  req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [3:0]     rsp_data;
  logic           rsp_corrected;
  logic           rsp_uncorr;

  logic [CW-1:0]  codes [NR];

  int n_chk;
  int n_pass;

  typedef struct packed {
    logic [1:0]    id;
    logic [CW-1:0] code;
    logic [3:0]    data;
    logic          corr;
    logic          unc;
  } vec_t;

  an_decode_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_code      (req_code),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_corrected (rsp_corrected),
    .rsp_uncorr    (rsp_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_code[i*CW +: CW] = codes[i];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) codes[i] = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Present one word on one requester; lat = edges from the accept edge until rsp_valid
  task automatic submit(input logic [1:0] id, input logic [CW-1:0] code, output int lat);
    codes[id]     = code;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b0;
    tick;
    lat           = 1;
    req_valid[id] = 1'b0;
    while (!rsp_valid && lat < 60) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) codes[i] = '0;
    tick;
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", req_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if ({rsp_id, rsp_data, rsp_corrected, rsp_uncorr} !== 8'h00)
      $display("FAIL reset_payload got id=%0d data=%0d c=%b u=%b want all 0", rsp_id, rsp_data, rsp_corrected, rsp_uncorr);
    else n_pass++;
    req_valid = '0;
    tick;
    rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL idle_no_valid got %b want 0000", req_ready); else n_pass++;
    req_valid = 4'b0100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) $display("FAIL idle_single_grant got %b want 0100", req_ready); else n_pass++;
    req_valid = 4'b1010;
    #1;
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL idle_rr_from_0 got %b want 0010", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_decode;
    vec_t v [12];
    int   lat;
    v[0]  = '{2'd0, 9'd133, 4'd7,  1'b0, 1'b0};  // clean 19*7
    v[1]  = '{2'd1, 9'd141, 4'd7,  1'b1, 1'b0};  // +8 error, r=8
    v[2]  = '{2'd2, 9'd132, 4'd7,  1'b1, 1'b0};  // -1 error, r=18
    v[3]  = '{2'd3, 9'd511, 4'd0,  1'b0, 1'b1};  // r=17, +2 overflows to 513
    v[4]  = '{2'd0, 9'd0,   4'd0,  1'b0, 1'b0};  // zero word
    v[5]  = '{2'd1, 9'd285, 4'd15, 1'b0, 1'b0};  // largest in-range quotient
    v[6]  = '{2'd2, 9'd380, 4'd0,  1'b0, 1'b1};  // quotient 20 out of range
    v[7]  = '{2'd3, 9'd256, 4'd0,  1'b1, 1'b0};  // r=9 -> subtract 256 -> 0
    v[8]  = '{2'd1, 9'd117, 4'd7,  1'b1, 1'b0};  // r=3 -> add 16
    v[9]  = '{2'd0, 9'd381, 4'd0,  1'b0, 1'b1};  // corrects to 380, quotient too big
    v[10] = '{2'd2, 9'd13,  4'd0,  1'b0, 1'b1};  // r=13 -> 13-32 negative
    v[11] = '{2'd3, 9'd18,  4'd1,  1'b1, 1'b0};  // r=18 -> 19
    do_reset;
    for (int i = 0; i < 12; i++) begin
      submit(v[i].id, v[i].code, lat);
      n_chk++; if (lat !== 20) $display("FAIL dec%0d_latency got %0d want 20", i, lat); else n_pass++;
      n_chk++; if (rsp_id !== v[i].id) $display("FAIL dec%0d_id got %0d want %0d", i, rsp_id, v[i].id); else n_pass++;
      n_chk++; if (rsp_data !== v[i].data) $display("FAIL dec%0d_data got %0d want %0d", i, rsp_data, v[i].data); else n_pass++;
      n_chk++; if (rsp_corrected !== v[i].corr) $display("FAIL dec%0d_corrected got %b want %b", i, rsp_corrected, v[i].corr); else n_pass++;
      n_chk++; if (rsp_uncorr !== v[i].unc) $display("FAIL dec%0d_uncorr got %b want %b", i, rsp_uncorr, v[i].unc); else n_pass++;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      n_chk++; if (rsp_valid !== 1'b0) $display("FAIL dec%0d_release got %b want 0", i, rsp_valid); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int         n;
    logic [1:0] exp_id;
    do_reset;
    for (int i = 0; i < NR; i++) codes[i] = CW'(19 * (i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      n = 1;
      while (!rsp_valid && n < 60) begin
        tick;
        n++;
      end
      exp_id = 2'(k % 4);
      n_chk++; if (n !== ((k == 0) ? 20 : 21)) $display("FAIL b2b%0d_interval got %0d want %0d", k, n, (k == 0) ? 20 : 21); else n_pass++;
      n_chk++; if (rsp_id !== exp_id) $display("FAIL b2b%0d_id got %0d want %0d", k, rsp_id, exp_id); else n_pass++;
      n_chk++; if (rsp_data !== 4'(exp_id + 2'd1)) $display("FAIL b2b%0d_data got %0d want %0d", k, rsp_data, exp_id + 1); else n_pass++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    do_reset;
    submit(2'd3, 9'd137, lat);
    n_chk++; if (lat !== 20) $display("FAIL bp_latency got %0d want 20", lat); else n_pass++;
    req_valid[0] = 1'b1;
    codes[0]     = 9'd57;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (rsp_valid !== 1'b1) $display("FAIL bp%0d_valid got %b want 1", c, rsp_valid); else n_pass++;
      n_chk++; if ({rsp_id, rsp_data, rsp_corrected, rsp_uncorr} !== {2'd3, 4'd7, 1'b1, 1'b0})
        $display("FAIL bp%0d_payload got id=%0d data=%0d c=%b u=%b want id=3 data=7 c=1 u=0", c, rsp_id, rsp_data, rsp_corrected, rsp_uncorr);
      else n_pass++;
      n_chk++; if (req_ready !== 4'b0000) $display("FAIL bp%0d_req_ready got %b want 0000", c, req_ready); else n_pass++;
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL bp_wrap_grant got %b want 0001", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid_job;
    int n;
    do_reset;
    codes[1]  = 9'd133;
    req_valid = 4'b0010;
    tick;
    req_valid = '0;
    for (int c = 0; c < 12; c++) tick;
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL mid_busy_ready got %b want 0000", req_ready); else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", rsp_valid); else n_pass++;
    codes[0]  = 9'd57;
    codes[2]  = 9'd133;
    req_valid = 4'b0101;
    #1;
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL mid_rst_pointer got %b want 0001", req_ready); else n_pass++;
    tick;
    req_valid = '0;
    n = 1;
    while (!rsp_valid && n < 60) begin
      tick;
      n++;
    end
    n_chk++; if (n !== 20) $display("FAIL mid_next_latency got %0d want 20", n); else n_pass++;
    n_chk++; if (rsp_id !== 2'd0) $display("FAIL mid_next_id got %0d want 0", rsp_id); else n_pass++;
    n_chk++; if (rsp_data !== 4'd3) $display("FAIL mid_next_data got %0d want 3", rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) codes[i] = '0;
    test_reset;
    test_decode;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_job;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
